// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam int unsigned ParityNone = 0;
    localparam int unsigned ParityOdd  = 1;
    localparam int unsigned ParityEven = 2;

    // Expected parity bit given the XOR of the data bits.
    function automatic logic parity_bit(input logic data_xor, input int unsigned mode);
        return (mode == ParityOdd) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability chain on the raw rx pin plus a falling-edge (start) detector.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic start_edge
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Preset high so a line idling high never looks like a start edge out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detection, bit-rate generator gating, data/parity/stop
// sampling and a valid/ready byte output with error and overrun flags.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 bps_tick,
    output logic                 bps_run,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CntW = 3;

    logic rx_s;
    logic start_edge;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_s      (rx_s),
        .start_edge(start_edge)
    );

    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_int_q, par_err_int_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 bps_run_q, bps_run_d;
    logic                 accept;

    assign accept = rx_valid_q & rx_ready;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_err_int_d = par_err_int_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        parity_err_d  = parity_err_q;
        frame_err_d   = frame_err_q;
        overrun_d     = overrun_q;
        bps_run_d     = bps_run_q;

        if (accept) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d   = StStart;
                    bps_run_d = 1'b1;
                end
            end
            StStart: begin
                if (bps_tick) begin
                    if (rx_s) begin
                        state_d   = StIdle;
                        bps_run_d = 1'b0;
                    end else begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
            end
            StData: begin
                if (bps_tick) begin
                    // LSB arrives first, so shifting into the MSB leaves it at bit 0.
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CntW'(DATA_BITS - 1)) begin
                        state_d = (PARITY_MODE == ParityNone) ? StStop : StParity;
                    end
                end
            end
            StParity: begin
                if (bps_tick) begin
                    par_err_int_d = rx_s ^ parity_bit(^shift_q, PARITY_MODE);
                    state_d       = StStop;
                end
            end
            StStop: begin
                if (bps_tick) begin
                    rx_data_d    = shift_q;
                    parity_err_d = (PARITY_MODE != ParityNone) & par_err_int_q;
                    frame_err_d  = ~rx_s;
                    rx_valid_d   = 1'b1;
                    if (rx_valid_q & ~rx_ready) begin
                        overrun_d = 1'b1;
                    end
                    state_d   = StIdle;
                    bps_run_d = 1'b0;
                end
            end
            default: begin
                state_d   = StIdle;
                bps_run_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_err_int_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            bps_run_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_err_int_q <= par_err_int_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
            bps_run_q     <= bps_run_d;
        end
    end

    assign bps_run    = bps_run_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: one no-parity and one even-parity instance, each with its own
// bit-rate generator (shortened bit period; the receiver only follows the generator's ticks).
module tb_uart_rx_ctrl;

    localparam int BitClks = 64;

    typedef struct packed {
        logic       valid;
        logic       perr;
        logic       ferr;
        logic       ovr;
        logic       busy;
        logic       run;
        logic [7:0] data;
    } out_t;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
        logic       par_bit;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx0 = 1'b1, rx2 = 1'b1;
    logic tick0, tick2, run0, run2;
    logic [7:0] data0, data2;
    logic valid0, valid2, ready0, ready2;
    logic perr0, perr2, ferr0, ferr2, ovr0, ovr2, busy0, busy2;
    logic rdy_seq0 = 1'b0, rdy_seq2 = 1'b0, rdy_rand0 = 1'b0, rdy_rand2 = 1'b0;
    logic mon_en = 1'b0;
    int   cnt0 = 0, cnt2 = 0;
    int   cyc = 0;
    int   total = 0, bad = 0;
    exp_t q0[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit-rate generators: counter held at 0 while bps_run is low, mid-bit pulse.
    always @(posedge clk) begin
        cnt0 <= !run0 ? 0 : (cnt0 == BitClks - 1) ? 0 : cnt0 + 1;
        cnt2 <= !run2 ? 0 : (cnt2 == BitClks - 1) ? 0 : cnt2 + 1;
    end
    assign tick0 = (cnt0 == BitClks / 2 - 1);
    assign tick2 = (cnt2 == BitClks / 2 - 1);

    assign ready0 = mon_en ? rdy_rand0 : rdy_seq0;
    assign ready2 = mon_en ? rdy_rand2 : rdy_seq2;

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_MODE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .bps_tick(tick0), .bps_run(run0),
        .rx_data(data0), .rx_valid(valid0), .rx_ready(ready0), .parity_err(perr0),
        .frame_err(ferr0), .overrun(ovr0), .busy(busy0)
    );

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_MODE(2), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .rx(rx2), .bps_tick(tick2), .bps_run(run2),
        .rx_data(data2), .rx_valid(valid2), .rx_ready(ready2), .parity_err(perr2),
        .frame_err(ferr2), .overrun(ovr2), .busy(busy2)
    );

    function automatic out_t outs(input int sel);
        if (sel == 0) return '{valid0, perr0, ferr0, ovr0, busy0, run0, data0};
        return '{valid2, perr2, ferr2, ovr2, busy2, run2, data2};
    endfunction

    // Even parity: data plus parity bit must hold an even number of ones.
    function automatic logic model_perr(input logic [7:0] d, input logic pb);
        return ((($countones(d) + int'(pb)) % 2) != 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else rx2 = v;
    endtask

    task automatic set_rdy(input int sel, input logic v);
        if (sel == 0) rdy_seq0 = v;
        else rdy_seq2 = v;
    endtask

    // Drives up to nbits line bits (start, data LSB first, parity on dut2, stop).
    task automatic send_frame(input int sel, input logic [7:0] d, input logic pb,
                              input logic stop, input int nbits);
        logic bits [11];
        int   n;
        n = (sel == 2) ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        if (sel == 2) bits[9] = pb;
        bits[n - 1] = stop;
        for (int b = 0; b < n && b < nbits; b++) begin
            set_rx(sel, bits[b]);
            repeat (BitClks) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (outs(sel).valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_valid dut%0d: no rx_valid within %0d clk", sel, budget);
        end
    endtask

    task automatic accept(input int sel);
        set_rdy(sel, 1'b1);
        @(negedge clk);
        set_rdy(sel, 1'b0);
    endtask

    // Scoreboard for the randomized phase: random ready, compare every accepted byte.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            rdy_rand0 = 1'($urandom_range(0, 1));
            rdy_rand2 = 1'($urandom_range(0, 1));
            if (valid0 && rdy_rand0) begin
                if (q0.size() == 0) check("rand0_unexpected", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("rand0_byte", {data0, perr0, ferr0, ovr0}, {e.data, e.perr, e.ferr, 1'b0});
                end
            end
            if (valid2 && rdy_rand2) begin
                if (q2.size() == 0) check("rand2_unexpected", 1, 0);
                else begin
                    e = q2.pop_front();
                    check("rand2_byte", {data2, perr2, ferr2, ovr2}, {e.data, e.perr, e.ferr, 1'b0});
                end
            end
        end
    end

    initial begin
        vec_t vecs [7];
        bit   ok, prev_busy, seen_busy, seen_valid;
        int   t0, t_rise, sel;
        out_t o;

        vecs[0] = '{2'd0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[1] = '{2'd0, 8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1};
        vecs[2] = '{2'd2, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
        vecs[3] = '{2'd2, 8'hA3, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
        vecs[4] = '{2'd2, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{2'd2, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[6] = '{2'd0, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_dut0", outs(0), '0);
        check("reset_dut2", outs(2), '0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 0x55, exact latency, busy falls as rx_valid rises.
        t0 = 0;
        t_rise = 0;
        prev_busy = 1'b0;
        ok = 1'b0;
        fork
            send_frame(0, 8'h55, 1'b0, 1'b1, 99);
            begin
                t0 = cyc;
                for (int i = 0; i < 20 * BitClks; i++) begin
                    @(negedge clk);
                    if (valid0) begin
                        ok = 1'b1;
                        t_rise = cyc;
                        break;
                    end
                    prev_busy = busy0;
                end
            end
        join
        check("lat_seen", ok, 1);
        check("lat_clks", t_rise - t0, 2 + 9 * BitClks + BitClks / 2 + 1);
        check("lat_busy_before", prev_busy, 1);
        o = outs(0);
        check("b55_out", {o.data, o.perr, o.ferr, o.ovr, o.busy, o.run},
              {8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        accept(0);
        check("b55_accept", {valid0, data0}, {1'b0, 8'h55});

        // Short low glitch: caught by the start sample, nothing delivered.
        seen_busy = 1'b0;
        seen_valid = 1'b0;
        rx0 = 1'b0;
        for (int i = 0; i < 2 * BitClks; i++) begin
            if (i == 20) rx0 = 1'b1;
            @(negedge clk);
            seen_busy |= busy0;
            seen_valid |= valid0;
        end
        check("glitch_detected", seen_busy, 1);
        check("glitch_no_valid", seen_valid, 0);
        check("glitch_idle", {busy0, run0}, 2'b00);

        // Table of single frames.
        for (int v = 0; v < 7; v++) begin
            sel = int'(vecs[v].sel);
            send_frame(sel, vecs[v].data, vecs[v].par_bit, vecs[v].stop, 99);
            set_rx(sel, 1'b1);
            wait_valid(sel, 4 * BitClks, ok);
            o = outs(sel);
            check($sformatf("vec%0d_out", v), {o.data, o.perr, o.ferr, o.ovr, o.busy, o.run},
                  {vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr, 3'b000});
            accept(sel);
            o = outs(sel);
            check($sformatf("vec%0d_hold", v), {o.valid, o.data, o.perr, o.ferr},
                  {1'b0, vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr});
            repeat (BitClks) @(negedge clk);
        end

        // Frame error with the line then held low: no new start until it goes high.
        send_frame(0, 8'h0F, 1'b0, 1'b0, 99);
        wait_valid(0, 4 * BitClks, ok);
        check("ferr_out", {data0, perr0, ferr0}, {8'h0F, 1'b0, 1'b1});
        accept(0);
        seen_busy = 1'b0;
        seen_valid = 1'b0;
        repeat (20 * BitClks) begin
            @(negedge clk);
            seen_busy |= busy0;
            seen_valid |= valid0;
        end
        check("low_no_start", {seen_busy, seen_valid}, 2'b00);
        rx0 = 1'b1;
        repeat (BitClks) @(negedge clk);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 99);
        wait_valid(0, 4 * BitClks, ok);
        check("after_low_out", {data0, perr0, ferr0}, {8'h5A, 1'b0, 1'b0});
        accept(0);

        // Back-to-back with ready low: second byte overwrites and sets overrun.
        send_frame(0, 8'h11, 1'b0, 1'b1, 99);
        send_frame(0, 8'h22, 1'b0, 1'b1, 99);
        wait_valid(0, 4 * BitClks, ok);
        check("ovr_out", {valid0, data0, ovr0}, {1'b1, 8'h22, 1'b1});
        accept(0);
        check("ovr_clear", {valid0, data0, ovr0}, {1'b0, 8'h22, 1'b0});

        // Reset in the middle of data bit 4.
        send_frame(0, 8'hC6, 1'b0, 1'b1, 5);
        rx0 = 1'b0;
        repeat (BitClks / 2) @(negedge clk);
        check("pre_reset_busy", busy0, 1);
        reset = 1'b0;
        #1;
        check("mid_reset", {busy0, run0, valid0}, 3'b000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rx0 = 1'b1;
        repeat (2 * BitClks) @(negedge clk);
        check("post_reset_idle", {busy0, valid0}, 2'b00);
        send_frame(0, 8'hC6, 1'b0, 1'b1, 99);
        wait_valid(0, 4 * BitClks, ok);
        check("c6_out", {data0, perr0, ferr0, ovr0}, {8'hC6, 1'b0, 1'b0, 1'b0});
        accept(0);
        repeat (BitClks) @(negedge clk);

        // Randomized frames on both instances against the scoreboard.
        mon_en = 1'b1;
        fork
            for (int f = 0; f < 12; f++) begin
                logic [7:0] d;
                logic       st;
                d = 8'($urandom);
                st = ($urandom_range(0, 3) != 0);
                q0.push_back('{d, 1'b0, ~st});
                send_frame(0, d, 1'b0, st, 99);
                rx0 = 1'b1;
                repeat ($urandom_range(1, BitClks)) @(negedge clk);
            end
            for (int f = 0; f < 12; f++) begin
                logic [7:0] d;
                logic       st, pb;
                d = 8'($urandom);
                st = ($urandom_range(0, 3) != 0);
                pb = 1'($urandom_range(0, 1));
                q2.push_back('{d, model_perr(d, pb), ~st});
                send_frame(2, d, pb, st, 99);
                rx2 = 1'b1;
                repeat ($urandom_range(1, BitClks)) @(negedge clk);
            end
        join
        repeat (2 * BitClks) @(negedge clk);
        mon_en = 1'b0;
        check("rand0_drained", q0.size(), 0);
        check("rand2_drained", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
